// File: rtl/evt_stretch_pkg.sv
// ----------------------------------------------------------------------------
// evt_stretch_pkg
//   Shared types and width helpers for the event stretcher.
//   - state_t   : pulse FSM state (IDLE / ON / GAP)
//   - pend_w_f  : width of the pending-event counter for a given queue depth
//   - tick_w_f  : width of the per-window tick counter
// ----------------------------------------------------------------------------
package evt_stretch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      GAP  = 2'd2
   } state_t;

   // Enough bits to hold 0..max_pend inclusive.
   function automatic int pend_w_f(input int max_pend);
      return $clog2(max_pend + 1);
   endfunction

   // Enough bits to hold 0..max(on_t, off_t) inclusive.
   function automatic int tick_w_f(input int on_t, input int off_t);
      return $clog2(((on_t > off_t) ? on_t : off_t) + 1);
   endfunction

endpackage

// File: rtl/evt_stretch_drv_tick_div.sv
// ----------------------------------------------------------------------------
// tick_div
//   Free-running DIV_W-bit prescaler. Emits a single-cycle tick when the
//   count is all-ones, i.e. once every 2^DIV_W cycles after a restart.
//   Ports:
//     clk     in   system clock
//     rst     in   synchronous reset, active-low (count -> 0)
//     restart in   synchronous restart (count -> 0 on the next edge)
//     tick    out  high for one cycle when count == all-ones
// ----------------------------------------------------------------------------
module tick_div
   import evt_stretch_pkg::*;
#(
   parameter int DIV_W = 12
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);

   logic [DIV_W-1:0] cnt_q;
   logic [DIV_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q + DIV_W'(1);
      if (restart) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = &cnt_q;

endmodule

// File: rtl/evt_stretch_drv.sv
// ----------------------------------------------------------------------------
// evt_stretch_drv
//   Turns single-cycle event pulses into human-visible output pulses: each
//   event gives ON_TICKS ticks high followed by OFF_TICKS ticks low, with one
//   tick = 2^DIV_W clk cycles. Events arriving while busy are queued (up to
//   MAX_PEND); further events are dropped and flagged by a sticky overflow.
//
//   Build option: define EVT_STRETCH_EDGE_EN to treat evt as a level and
//   use a registered rising-edge detector (adds one cycle of latency).
//
//   Ports:
//     clk      in   system clock
//     rst      in   synchronous reset, active-low
//     evt      in   event request (pulse, or level when edge mode is built)
//     flush    in   abort current pulse, discard queued events
//     clr_ovf  in   clear sticky overflow flag (a same-cycle set wins)
//     out      out  registered stretched pulse
//     busy     out  state is not IDLE
//     pend     out  number of queued events
//     ovf      out  sticky: an event was dropped because the queue was full
// ----------------------------------------------------------------------------
module evt_stretch_drv
   import evt_stretch_pkg::*;
#(
   parameter  int DIV_W     = 12,
   parameter  int ON_TICKS  = 4,
   parameter  int OFF_TICKS = 2,
   parameter  int MAX_PEND  = 7,
   localparam int PEND_W    = pend_w_f(MAX_PEND)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              evt,
   input  logic              flush,
   input  logic              clr_ovf,
   output logic              out,
   output logic              busy,
   output logic [PEND_W-1:0] pend,
   output logic              ovf
);

   localparam int TICK_W = tick_w_f(ON_TICKS, OFF_TICKS);
   localparam logic [TICK_W-1:0] ON_LAST  = TICK_W'(ON_TICKS - 1);
   localparam logic [TICK_W-1:0] OFF_LAST = TICK_W'(OFF_TICKS - 1);
   localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PEND);

   state_t              state_q, state_d;
   logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
   logic [PEND_W-1:0]   pend_q, pend_d;
   logic                ovf_q, ovf_d;
   logic                out_q, out_d;

   logic                ev;
   logic                tick;
   logic                div_restart;
   logic                on_end;
   logic                gap_end;

   // ---- event qualification ----
`ifdef EVT_STRETCH_EDGE_EN
   logic evt_prev_q, evt_prev_d;
   logic ev_q, ev_d;

   // A flush in the same cycle as a fresh edge swallows that edge.
   always_comb begin
      evt_prev_d = evt;
      ev_d       = evt & ~evt_prev_q & ~flush;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         evt_prev_q <= 1'b0;
         ev_q       <= 1'b0;
      end else begin
         evt_prev_q <= evt_prev_d;
         ev_q       <= ev_d;
      end
   end

   assign ev = ev_q;
`else
   assign ev = evt;
`endif

   // ---- tick prescaler ----
   // Restart on every state change so each window starts on a fresh count,
   // and hold at zero while idle.
   assign div_restart = (state_d != state_q) || (state_q == IDLE);

   tick_div #(
      .DIV_W (DIV_W)
   ) u_tick_div (
      .clk     (clk),
      .rst     (rst),
      .restart (div_restart),
      .tick    (tick)
   );

   assign on_end  = (state_q == ON)  && tick && (tick_cnt_q == ON_LAST);
   assign gap_end = (state_q == GAP) && tick && (tick_cnt_q == OFF_LAST);

   // ---- FSM: state register ----
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---- FSM: next state ----
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (ev) state_d = ON;
         end
         ON: begin
            if (on_end) state_d = GAP;
         end
         GAP: begin
            if (gap_end) begin
               state_d = ((pend_q != '0) || ev) ? ON : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (flush) state_d = IDLE;
   end

   // ---- FSM: outputs ----
   always_comb begin
      out_d = (state_d == ON);
      busy  = (state_q != IDLE);
   end

   // ---- counters and flags ----
   always_comb begin
      logic ovf_set;
      ovf_set    = 1'b0;
      tick_cnt_d = tick_cnt_q;
      pend_d     = pend_q;

      if (div_restart) begin
         tick_cnt_d = '0;
      end else if (tick) begin
         tick_cnt_d = tick_cnt_q + TICK_W'(1);
      end

      if (flush) begin
         pend_d = '0;
      end else if (gap_end && (pend_q != '0)) begin
         // Dequeue; a same-cycle event takes the freed slot.
         if (!ev) pend_d = pend_q - PEND_W'(1);
      end else if (ev && (state_q != IDLE) && !gap_end) begin
         // At a gap end with an empty queue the event starts ON directly.
         if (pend_q < PEND_MAX) begin
            pend_d = pend_q + PEND_W'(1);
         end else begin
            ovf_set = 1'b1;
         end
      end

      ovf_d = ovf_q;
      if (clr_ovf) ovf_d = 1'b0;
      if (ovf_set) ovf_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         tick_cnt_q <= '0;
         pend_q     <= '0;
         ovf_q      <= 1'b0;
         out_q      <= 1'b0;
      end else begin
         tick_cnt_q <= tick_cnt_d;
         pend_q     <= pend_d;
         ovf_q      <= ovf_d;
         out_q      <= out_d;
      end
   end

   assign out  = out_q;
   assign pend = pend_q;
   assign ovf  = ovf_q;

endmodule
